// File: rtl/adder_pipe_ctrl_32bits_if.sv
// Handshake and external-adder bundle for the two-stage adder pipeline controller.
// slave is the controller's view; master is the environment (source, sink and adder).
interface adder_pipe_ctrl_32bits_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             in_sub;
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic             add_cin;
  logic [WIDTH-1:0] add_s;
  logic             add_cout;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_zero;
  logic             out_neg;
  logic             out_ovf;

  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_sub, add_s, add_cout, out_ready,
    output in_ready, add_a, add_b, add_cin, out_valid, out_sum,
           out_cout, out_zero, out_neg, out_ovf
  );

  modport master (
    output in_valid, in_a, in_b, in_cin, in_sub, add_s, add_cout, out_ready,
    input  in_ready, add_a, add_b, add_cin, out_valid, out_sum,
           out_cout, out_zero, out_neg, out_ovf
  );
endinterface

// File: rtl/adder_pipe_ctrl_32bits.sv
// Two-stage valid/ready pipeline around an external combinational adder:
// S1 holds conditioned operands, S2 holds the sum and its flags.
module adder_pipe_ctrl_32bits #(
  parameter int WIDTH = 32
) (
  input logic                    clk,
  input logic                    rst,
  adder_pipe_ctrl_32bits_if.slave bus
);
  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic             s1_cin;

  logic             s2_valid;
  logic [WIDTH-1:0] s2_sum;
  logic             s2_cout;
  logic             s2_zero;
  logic             s2_neg;
  logic             s2_ovf;

  logic adv1;
  logic adv2;
  logic in_xfer;
  logic zero_c;
  logic neg_c;
  logic ovf_c;

  always_comb begin
    adv2    = !s2_valid || bus.out_ready;
    adv1    = !s1_valid || adv2;
    in_xfer = bus.in_valid && adv1;
    zero_c  = (bus.add_s == '0);
    neg_c   = bus.add_s[WIDTH-1];
    // Signed overflow: operands agree in sign but the sum does not.
    ovf_c   = (s1_a[WIDTH-1] == s1_b[WIDTH-1]) && (bus.add_s[WIDTH-1] != s1_a[WIDTH-1]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_cin   <= 1'b0;
      s2_valid <= 1'b0;
      s2_sum   <= '0;
      s2_cout  <= 1'b0;
      s2_zero  <= 1'b0;
      s2_neg   <= 1'b0;
      s2_ovf   <= 1'b0;
    end else begin
      if (adv1) begin
        s1_valid <= in_xfer;
        if (in_xfer) begin
          // Subtract is folded into an add: A + ~B + 1.
          s1_a   <= bus.in_a;
          s1_b   <= bus.in_sub ? ~bus.in_b : bus.in_b;
          s1_cin <= bus.in_sub ? 1'b1 : bus.in_cin;
        end
      end
      if (adv2) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_sum  <= bus.add_s;
          s2_cout <= bus.add_cout;
          s2_zero <= zero_c;
          s2_neg  <= neg_c;
          s2_ovf  <= ovf_c;
        end
      end
    end
  end

  assign bus.in_ready  = adv1;
  assign bus.add_a     = s1_a;
  assign bus.add_b     = s1_b;
  assign bus.add_cin   = s1_cin;
  assign bus.out_valid = s2_valid;
  assign bus.out_sum   = s2_sum;
  assign bus.out_cout  = s2_cout;
  assign bus.out_zero  = s2_zero;
  assign bus.out_neg   = s2_neg;
  assign bus.out_ovf   = s2_ovf;
endmodule

// File: tb/tb_adder_pipe_ctrl_32bits.sv
// Self-checking bench: directed corner cases plus randomized traffic scored
// against an arithmetic reference queue.
module tb_adder_pipe_ctrl_32bits;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  adder_pipe_ctrl_32bits_if #(.WIDTH(W)) bus ();
  adder_pipe_ctrl_32bits #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  // Behavioural external adder.
  assign {bus.add_cout, bus.add_s} = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {{W{1'b0}}, bus.add_cin};

  int          n_tests = 0;
  int          n_fail  = 0;
  int          out_cnt = 0;
  logic [35:0] exp_q[$];
  logic        prev_stall = 1'b0;
  logic [35:0] prev_out = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Result packed as {cout, zero, neg, ovf, sum}.
  function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic cin, input logic sub);
    logic [32:0] full;
    logic [31:0] sum;
    logic        cout;
    longint      sr;
    if (sub) begin
      full = {1'b0, a} - {1'b0, b};
      sr   = longint'($signed(a)) - longint'($signed(b));
      cout = (a >= b);
    end else begin
      full = {1'b0, a} + {1'b0, b} + {32'd0, cin};
      sr   = longint'($signed(a)) + longint'($signed(b)) + longint'(cin);
      cout = full[32];
    end
    sum = full[31:0];
    return {cout, (sum == 32'd0), sum[31], (sr != longint'($signed(sum))), sum};
  endfunction

  function automatic logic [35:0] observed();
    return {bus.out_cout, bus.out_zero, bus.out_neg, bus.out_ovf, bus.out_sum};
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  // Scoreboard: sample handshakes on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall) check("hold_stable", observed(), prev_out);
      if (bus.out_valid && bus.out_ready) begin
        out_cnt++;
        if (exp_q.size() == 0) check("spurious_out", 1, 0);
        else check("result", observed(), exp_q.pop_front());
      end
      if (bus.in_valid && bus.in_ready)
        exp_q.push_back(model(bus.in_a, bus.in_b, bus.in_cin, bus.in_sub));
      prev_stall <= bus.out_valid && !bus.out_ready;
      prev_out   <= observed();
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic sub);
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_cin   = cin;
    bus.in_sub   = sub;
    bus.in_valid = 1'b1;
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) tick();
  endtask

  // Present one op and return just after the edge that accepts it.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic sub);
    int n;
    n = 0;
    drive_op(a, b, cin, sub);
    @(negedge clk);
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("accept_timeout", 0, 1);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic send_expect(input string tag, input logic [31:0] a, input logic [31:0] b,
                             input logic cin, input logic sub,
                             input logic [31:0] exp_sum, input logic [3:0] exp_flags);
    int n;
    n = 0;
    send(a, b, cin, sub);
    @(negedge clk);
    while (!bus.out_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, bus.out_valid, 1);
    check({tag, "_sum"}, bus.out_sum, exp_sum);
    check({tag, "_flags"}, {bus.out_cout, bus.out_zero, bus.out_neg, bus.out_ovf}, exp_flags);
    tick();
  endtask

  initial begin
    int base;
    int n;
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    int n;
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_cin    = 1'b0;
    bus.in_sub    = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_sum", bus.out_sum, 0);
    check("rst_flags", {bus.out_cout, bus.out_zero, bus.out_neg, bus.out_ovf}, 0);
    check("rst_add_ops", {bus.add_a, bus.add_b, bus.add_cin}, 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", bus.in_ready, 1);
    tick();

    // Latency: accepted at edge k, visible after edge k+1.
    send(32'h5, 32'h3, 1'b0, 1'b0);
    @(negedge clk);
    check("lat_k_valid", bus.out_valid, 0);
    @(negedge clk);
    check("lat_k1_valid", bus.out_valid, 1);
    check("lat_sum", bus.out_sum, 32'h8);
    check("lat_flags", {bus.out_cout, bus.out_zero, bus.out_neg, bus.out_ovf}, 4'b0000);
    tick();
    idle(2);

    // Flags order: {cout, zero, neg, ovf}
    send_expect("add_ovf",  32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 4'b0011);
    send_expect("add_wrap", 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0,         4'b1100);
    send_expect("sub_neg",  32'h3,         32'h5, 1'b0, 1'b1, 32'hFFFF_FFFE, 4'b0010);
    send_expect("sub_zero", 32'hA,         32'hA, 1'b0, 1'b1, 32'h0,         4'b1100);
    send_expect("add_cin",  32'h1,         32'h1, 1'b1, 1'b0, 32'h3,         4'b0000);
    send_expect("sub_ovf",  32'h8000_0000, 32'h1, 1'b1, 1'b1, 32'h7FFF_FFFF, 4'b1001);
    idle(3);

    // Back-to-back stream of 8 with out_ready high.
    for (int j = 0; j < 11; j++) begin
      if (j < 8) drive_op($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      else bus.in_valid = 1'b0;
      @(negedge clk);
      if (j < 8) check("stream_ready", bus.in_ready, 1);
      check("stream_out_valid", bus.out_valid, (j >= 2 && j < 10));
      tick();
    end
    idle(2);

    // Backpressure: third op must stall while both stages are full.
    base = out_cnt;
    bus.out_ready = 1'b0;
    drive_op(32'd10, 32'd20, 1'b0, 1'b0);
    @(negedge clk);
    check("bp_ready0", bus.in_ready, 1);
    tick();
    drive_op(32'd100, 32'd7, 1'b0, 1'b1);
    @(negedge clk);
    check("bp_ready1", bus.in_ready, 1);
    tick();
    drive_op(32'd1, 32'd2, 1'b1, 1'b0);
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      check("bp_ready2", bus.in_ready, 0);
      check("bp_out_valid", bus.out_valid, 1);
      check("bp_out_held", observed(), model(32'd10, 32'd20, 1'b0, 1'b0));
      check("bp_add_held", {bus.add_a, bus.add_b, bus.add_cin}, {32'd100, ~32'd7, 1'b1});
      tick();
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_ready", bus.in_ready, 1);
    tick();
    idle(5);
    check("bp_delivered", out_cnt - base, 3);

    // Reset with both stages full discards everything.
    bus.out_ready = 1'b0;
    drive_op($urandom, $urandom, 1'b0, 1'b0);
    tick();
    drive_op($urandom, $urandom, 1'b0, 1'b1);
    tick();
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("full_before_rst", {bus.out_valid, bus.in_ready}, 2'b10);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("after_rst_valid", bus.out_valid, 0);
    check("after_rst_sum", bus.out_sum, 0);
    check("after_rst_flags", {bus.out_cout, bus.out_zero, bus.out_neg, bus.out_ovf}, 0);
    check("after_rst_add", {bus.add_a, bus.add_b, bus.add_cin}, 0);
    check("after_rst_ready", bus.in_ready, 1);
    tick();
    base = out_cnt;
    bus.out_ready = 1'b1;
    idle(6);
    check("no_stale_out", out_cnt - base, 0);

    // Randomized traffic with occasional reset.
    for (int i = 0; i < 400; i++) begin
      rst           = ($urandom_range(0, 149) == 0);
      bus.out_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 3) != 0) drive_op(pick(), pick(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      else bus.in_valid = 1'b0;
      tick();
    end
    rst           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    check("drain_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
